// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package if_prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// Fetch buffer: power-of-two ring of {addr, data}, head read combinationally.
module fetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_push,
    input  fetch_entry_t             i_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_do_pop;
    logic            w_do_push;

    // A pop frees the slot in the same edge, so push-on-full is legal with a pop.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: one outstanding RAM request at a time, results buffered
// in a small FIFO feeding the IF/ID register; redirects flush and drop stale data.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        stall_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic [31:0] fetch_addr_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(FIFO_DEPTH - 1);

    fetch_state_e   r_state;
    logic           r_req;
    logic [31:0]    r_pc;
    logic [31:0]    r_req_addr;

    fetch_entry_t   w_head;
    fetch_entry_t   w_entry;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic           w_pop;
    logic           w_push;
    logic           w_granted;
    logic           w_has_space;
    logic           w_space_after_push;

    assign w_granted   = (r_state == WAIT_GNT) && instr_gnt_i;
    assign w_pop       = !w_empty && !stall_i && !redirect_i;
    assign w_push      = (r_state == WAIT_RVALID) && instr_rvalid_i && !redirect_i;
    assign w_has_space = (w_count < FULL_CNT);
    // A request is only issued with a free slot, so a push never finds the buffer full.
    assign w_space_after_push = (w_count < LAST_CNT) || w_pop;

    assign w_entry.addr = r_req_addr;
    assign w_entry.data = instr_rdata_i;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_pc       <= BOOT_ADDR;
            r_req_addr <= BOOT_ADDR;
        end else begin
            if (redirect_i)     r_pc <= word_align(redirect_addr_i);
            else if (w_granted) r_pc <= r_pc + 32'd4;

            if (w_granted) r_req_addr <= r_pc;

            case (r_state)
                IDLE: begin
                    if (redirect_i || w_has_space) begin
                        r_state <= WAIT_GNT;
                        r_req   <= 1'b1;
                    end
                end
                WAIT_GNT: begin
                    // Redirect without a grant just retargets the pending request.
                    if (instr_gnt_i) begin
                        r_state <= redirect_i ? DISCARD : WAIT_RVALID;
                        r_req   <= 1'b0;
                    end
                end
                WAIT_RVALID: begin
                    if (instr_rvalid_i) begin
                        if (redirect_i || w_space_after_push) begin
                            r_state <= WAIT_GNT;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (redirect_i) begin
                        r_state <= DISCARD;
                    end
                end
                DISCARD: begin
                    // The stale response retires the outstanding request whatever the redirect does.
                    if (instr_rvalid_i) begin
                        r_state <= WAIT_GNT;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign instr_req_o   = r_req;
    assign instr_addr_o  = r_pc;
    assign fetch_valid_o = !w_empty;
    assign fetch_rdata_o = w_empty ? NOP_INSTR : w_head.data;
    assign fetch_addr_o  = w_empty ? 32'h0000_0000 : w_head.addr;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a small RAM responder answers grants one cycle later
// with data = ~address; the main sequence checks every expected value by hand.
module tb_if_prefetch;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i    = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i  = 32'h0;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        stall_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;

    logic        gnt_en;
    logic        rv_en;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    int nchk = 0;
    int nerr = 0;

    if_prefetch #(
        .BOOT_ADDR  (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .stall_i         (stall_i),
        .fetch_valid_o   (fetch_valid_o),
        .fetch_rdata_o   (fetch_rdata_o),
        .fetch_addr_o    (fetch_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: grant decided at negedge, response one cycle after the handshake.
    always @(negedge clk_i) begin
        instr_rvalid_i = 1'b0;
        if (pend && rv_en) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = ~pend_addr;
            pend           = 1'b0;
        end
        instr_gnt_i = gnt_en && instr_req_o;
        if (instr_gnt_i) begin
            pend      = 1'b1;
            pend_addr = instr_addr_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'h0, instr_req_o},   32'h0);
        chk({tag, "_iaddr"}, instr_addr_o,           32'h0);
        chk({tag, "_valid"}, {31'h0, fetch_valid_o}, 32'h0);
        chk({tag, "_rdata"}, fetch_rdata_o,          32'h0000_0013);
        chk({tag, "_faddr"}, fetch_addr_o,           32'h0);
    endtask

    initial begin
        rst_ni = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = 32'h0;
        gnt_en = 1'b1; rv_en = 1'b1;
        tick(); tick();
        chk_reset_outputs("reset");

        // Sequential fetch, gnt always, rvalid one cycle later.
        rst_ni = 1'b1;
        tick();
        chk("first_req",  {31'h0, instr_req_o}, 32'h1);
        chk("first_addr", instr_addr_o, 32'h0);
        tick();
        chk("wrv_req", {31'h0, instr_req_o}, 32'h0);
        tick();
        chk("f0_valid", {31'h0, fetch_valid_o}, 32'h1);
        chk("f0_addr",  fetch_addr_o,  32'h0);
        chk("f0_rdata", fetch_rdata_o, 32'hFFFF_FFFF);
        chk("req4",     instr_addr_o,  32'h4);
        tick();
        chk("popped_valid", {31'h0, fetch_valid_o}, 32'h0);
        tick();
        chk("f4_addr",  fetch_addr_o,  32'h4);
        chk("f4_rdata", fetch_rdata_o, 32'hFFFF_FFFB);
        chk("req8",     instr_addr_o,  32'h8);

        // Stall: buffer fills, requests stop, head held.
        stall_i = 1'b1;
        tick();
        chk("stall_hold0", fetch_addr_o, 32'h4);
        tick();
        chk("full_req",   {31'h0, instr_req_o}, 32'h0);
        chk("stall_hold1", fetch_addr_o, 32'h4);
        tick(); tick();
        chk("full_req2",   {31'h0, instr_req_o}, 32'h0);
        chk("stall_hold2", fetch_addr_o, 32'h4);
        chk("stall_valid", {31'h0, fetch_valid_o}, 32'h1);
        tick();
        stall_i = 1'b0;
        tick();
        chk("unstall_f8",    fetch_addr_o,  32'h8);
        chk("unstall_rdata", fetch_rdata_o, 32'hFFFF_FFF7);
        chk("unstall_req",   {31'h0, instr_req_o}, 32'h0);
        tick();
        chk("drain_valid", {31'h0, fetch_valid_o}, 32'h0);
        chk("req_c_on",    {31'h0, instr_req_o}, 32'h1);
        chk("req_c_addr",  instr_addr_o, 32'hC);

        // Redirect while awaiting rvalid; the late response must be dropped.
        rv_en = 1'b0;
        tick();
        chk("wrv_c_req", {31'h0, instr_req_o}, 32'h0);
        redirect_i = 1'b1; redirect_addr_i = 32'h0000_1002;
        tick();
        redirect_i = 1'b0;
        chk("disc_valid", {31'h0, fetch_valid_o}, 32'h0);
        chk("disc_req",   {31'h0, instr_req_o}, 32'h0);
        chk("disc_pc",    instr_addr_o, 32'h0000_1000);
        rv_en = 1'b1;
        tick();
        chk("stale_dropped", {31'h0, fetch_valid_o}, 32'h0);
        chk("redir_req",     {31'h0, instr_req_o}, 32'h1);
        chk("redir_addr",    instr_addr_o, 32'h0000_1000);

        // Grant held off for four cycles.
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("nognt_req",  {31'h0, instr_req_o}, 32'h1);
            chk("nognt_addr", instr_addr_o, 32'h0000_1000);
        end
        gnt_en = 1'b1;
        tick(); tick();
        chk("f1000_addr",  fetch_addr_o,  32'h0000_1000);
        chk("f1000_rdata", fetch_rdata_o, 32'hFFFF_EFFF);
        chk("req1004",     instr_addr_o,  32'h0000_1004);

        // Redirect in WAIT_GNT (no grant), then wrap the PC.
        gnt_en = 1'b0; redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0; gnt_en = 1'b1;
        chk("flush_valid", {31'h0, fetch_valid_o}, 32'h0);
        chk("top_req",     {31'h0, instr_req_o}, 32'h1);
        chk("top_addr",    instr_addr_o, 32'hFFFF_FFFC);
        tick(); tick();
        chk("wrap_addr",  instr_addr_o,  32'h0);
        chk("wrap_req",   {31'h0, instr_req_o}, 32'h1);
        chk("top_faddr",  fetch_addr_o,  32'hFFFF_FFFC);
        chk("top_rdata",  fetch_rdata_o, 32'h0000_0003);

        // Asynchronous reset during WAIT_RVALID, stray rvalid after release.
        stall_i = 1'b1;
        tick();
        chk("pre_rst_req", {31'h0, instr_req_o}, 32'h0);
        rv_en = 1'b0; rst_ni = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_ni = 1'b1; rv_en = 1'b1;
        tick();
        chk("stray_valid", {31'h0, fetch_valid_o}, 32'h0);
        chk("rst_req",     {31'h0, instr_req_o}, 32'h1);
        chk("rst_addr",    instr_addr_o, 32'h0);
        tick(); tick();
        chk("rst_f0_valid", {31'h0, fetch_valid_o}, 32'h1);
        chk("rst_f0_addr",  fetch_addr_o,  32'h0);
        chk("rst_f0_rdata", fetch_rdata_o, 32'hFFFF_FFFF);
        chk("rst_req4",     instr_addr_o,  32'h4);

        // Redirect coincident with grant: response for the old PC is discarded.
        redirect_i = 1'b1; redirect_addr_i = 32'h0000_2000;
        tick();
        redirect_i = 1'b0;
        chk("cg_valid", {31'h0, fetch_valid_o}, 32'h0);
        chk("cg_req",   {31'h0, instr_req_o}, 32'h0);
        chk("cg_pc",    instr_addr_o, 32'h0000_2000);
        tick();
        chk("cg_drop_valid", {31'h0, fetch_valid_o}, 32'h0);
        chk("cg_req2",       {31'h0, instr_req_o}, 32'h1);
        chk("cg_addr2",      instr_addr_o, 32'h0000_2000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter BOOT_ADDR, 32'h0000_0000, first fetch address after reset (word aligned).
REQ-002 Parameter FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2).
REQ-003 clk_i  in  1  clock, all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 instr_req_o  out  1  instruction RAM request.
REQ-006 instr_addr_o  out  32  instruction RAM word address, bits[1:0] always 0.
REQ-007 instr_gnt_i  in  1  RAM accepts request this cycle.
REQ-008 instr_rvalid_i  in  1  instr_rdata_i valid for oldest granted request.
REQ-009 instr_rdata_i  in  32  RAM read data.
REQ-010 redirect_i  in  1  branch/jump/exception redirect from ctrl.
REQ-011 redirect_addr_i  in  32  redirect target.
REQ-012 stall_i  in  1  downstream IF/ID register holding; do not pop.
REQ-013 fetch_valid_o  out  1  fetch_rdata_o/fetch_addr_o hold a real instruction.
REQ-014 fetch_rdata_o  out  32  instruction to IF/ID register.
REQ-015 fetch_addr_o  out  32  address of fetch_rdata_o.

Function
REQ-016 FSM states: IDLE, WAIT_GNT, WAIT_RVALID, DISCARD.
REQ-017 IDLE->WAIT_GNT when (fifo_count + outstanding) < FIFO_DEPTH; instr_req_o=1 in WAIT_GNT only.
REQ-018 instr_addr_o and instr_req_o held stable in WAIT_GNT until instr_gnt_i=1.
REQ-019 On gnt: PC <= PC+4 (mod 2^32, wrap 0xFFFF_FFFC->0), state->WAIT_RVALID; max one outstanding request.
REQ-020 WAIT_RVALID + rvalid: push {PC_of_request, rdata} into FIFO; go WAIT_GNT if space remains else IDLE (same-cycle pop counts as space).
REQ-021 rvalid outside WAIT_RVALID/DISCARD ignored.
REQ-022 Pop when fetch_valid_o=1 and stall_i=0; FIFO head drives fetch_* combinationally.
REQ-023 FIFO empty: fetch_valid_o=0, fetch_rdata_o=32'h0000_0013 (NOP), fetch_addr_o=0.
REQ-024 Full FIFO: no request issued; simultaneous push and pop on full allowed, count unchanged.
REQ-025 Push on empty with no stall: data visible at fetch_* next cycle (1-cycle rvalid-to-output latency).
REQ-026 redirect_i: FIFO flushed same edge, PC <= {redirect_addr_i[31:2],2'b00}; no pop that cycle.
REQ-027 Redirect in WAIT_GNT: request withdrawn next cycle and reissued at new PC (or already-granted case per REQ-028).
REQ-028 Redirect in WAIT_RVALID, or coincident with gnt: state->DISCARD; arriving rvalid dropped, then WAIT_GNT.
REQ-029 Redirect coincident with rvalid in WAIT_RVALID: data dropped, state->WAIT_GNT at new PC.
REQ-030 Redirect in DISCARD: PC updated, remain DISCARD.
REQ-031 Redirect has priority over stall_i; stall_i never blocks fetching into free FIFO space.

Reset
REQ-032 Reset: state IDLE, PC=BOOT_ADDR, FIFO empty, instr_req_o=0, instr_addr_o=BOOT_ADDR, fetch_valid_o=0, fetch_rdata_o=32'h13, fetch_addr_o=0.
REQ-033 Reset mid-transaction: pending rvalid after deassert ignored (state IDLE).
REQ-034 First request asserted first cycle after rst_ni rises.

Structure
REQ-035 Shared package: FSM state enum, NOP constant 32'h0000_0013, BOOT_ADDR default.
REQ-036 One sub-module fetch_fifo (parameterised depth, push/pop/flush, count).

Verification
REQ-037 Reset release, gnt=1 always, rvalid 1 cycle after gnt -> addresses 0x0,0x4,0x8 requested; fetch_addr_o 0x0,0x4 consecutive.
REQ-038 stall_i=1 for 5 cycles -> FIFO fills to 2, instr_req_o=0, fetch_* held at same entry; release -> pop continues, no loss/duplication.
REQ-039 redirect_i to 0x0000_1002 while WAIT_RVALID -> late rvalid discarded, next request addr 0x0000_1000, fetch_valid_o=0 until its rvalid.
REQ-040 gnt held low 4 cycles -> instr_addr_o/instr_req_o stable throughout.
REQ-041 PC=0xFFFF_FFFC granted -> next request addr 0x0000_0000.
REQ-042 rst_ni asserted during WAIT_RVALID -> outputs at REQ-032 values immediately; stray rvalid after release not pushed.
